// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
//   Shares one spi_flash_read engine between two read requesters.
//   Port 0 is CPU fetch/load and port 1 is a DMA/video fetcher.
//   Only one burst runs at a time. The engine's strobes and done are routed
//   back to the owner, and a watchdog aborts a burst that has stalled.
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   rN_req/addr/count             level request plus burst parameters (sampled at grant)
//   rN_grant/strobe/done/error    ownership, word-valid, burst-end and abort flags
//   rd_data                       engine data passed straight through
//   eng_start/address/word_count  engine command (start held for the whole burst)
//   eng_strobe/done/data_out      engine responses
//   busy                          arbiter is not idle
module spi_flash_arbiter #(
  parameter int MAX_BURST       = 256,
  parameter int FIXED_PRIORITY  = 0,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic [23:0] r0_addr,
  input  logic [23:0] r0_count,
  input  logic        r1_req,
  input  logic [23:0] r1_addr,
  input  logic [23:0] r1_count,
  output logic        r0_grant,
  output logic        r0_strobe,
  output logic        r0_done,
  output logic        r0_error,
  output logic        r1_grant,
  output logic        r1_strobe,
  output logic        r1_done,
  output logic        r1_error,
  output logic [31:0] rd_data,
  output logic        eng_start,
  output logic [23:0] eng_address,
  output logic [23:0] eng_word_count,
  input  logic        eng_strobe,
  input  logic        eng_done,
  input  logic [31:0] eng_data_out,
  output logic        busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam int             WDW    = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'(WATCHDOG_CYCLES);
  localparam logic [23:0]    MAXB   = 24'(MAX_BURST);

  logic [1:0]     state_q, state_d;
  logic           owner_q, last_owner_q;
  logic [23:0]    addr_q, count_q, word_cnt_q;
  logic [WDW-1:0] wd_q;

  logic        any_req, sel1, run, abrt, wd_hit;
  logic [23:0] req_cnt, clamp_cnt;

  assign any_req = r0_req | r1_req;
  // Round-robin: on a tie the port not served last wins; a lone requester always wins.
  assign sel1 = (FIXED_PRIORITY != 0) ? (r1_req & ~r0_req)
                                      : (r1_req & (~r0_req | ~last_owner_q));
  assign req_cnt   = sel1 ? r1_count : r0_count;
  assign clamp_cnt = (req_cnt == 24'd0) ? 24'd1 : (req_cnt > MAXB) ? MAXB : req_cnt;

  assign run    = (state_q == RUN);
  assign abrt   = (state_q == ABORT);
  // wd_q saturates at WD_MAX; reaching it with no strobe this cycle aborts on the next edge.
  assign wd_hit = (WATCHDOG_CYCLES != 0) && (wd_q == WD_MAX) && !eng_strobe;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = RUN;
      RUN:     if (eng_done) state_d = GAP;
               else if (wd_hit) state_d = ABORT;
      ABORT:   state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      addr_q       <= 24'd0;
      count_q      <= 24'd0;
      word_cnt_q   <= 24'd0;
      wd_q         <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        owner_q    <= sel1;
        addr_q     <= sel1 ? r1_addr : r0_addr;
        count_q    <= clamp_cnt;
        word_cnt_q <= 24'd0;
        wd_q       <= '0;
      end
      if (run) begin
        if (eng_strobe) begin
          word_cnt_q <= word_cnt_q + 24'd1;
          wd_q       <= '0;
        end else if (wd_q != WD_MAX) begin
          wd_q <= wd_q + 1'b1;
        end
        if (eng_done || wd_hit) last_owner_q <= owner_q;
      end
    end
  end

  assign r0_grant  = (run | abrt) & ~owner_q;
  assign r1_grant  = (run | abrt) &  owner_q;
  assign r0_strobe = run & eng_strobe & ~owner_q;
  assign r1_strobe = run & eng_strobe &  owner_q;
  assign r0_done   = ((run & eng_done) | abrt) & ~owner_q;
  assign r1_done   = ((run & eng_done) | abrt) &  owner_q;
  assign r0_error  = abrt & ~owner_q;
  assign r1_error  = abrt &  owner_q;

  assign rd_data        = eng_data_out;
  assign eng_start      = run;
  assign eng_address    = addr_q;
  assign eng_word_count = count_q;
  assign busy           = (state_q != IDLE);
endmodule
